// File: rtl/diretorio_pkg.sv
// Shared encodings for the two-cache coherence directory: entry states,
// controller FSM states and the default number of tracked blocks.
package diretorio_pkg;

  localparam int N_BLOCKS_DEF = 4;

  typedef enum logic [1:0] {
    ST_I = 2'd0,
    ST_S = 2'd1,
    ST_M = 2'd2
  } dirState_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    WAIT_ACK = 2'd2,
    GRANT    = 2'd3
  } fsmState_e;

  function automatic logic [1:0] oneHot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Two-way round-robin arbiter: cache 0 starts with priority, and priority
// flips every time the advance strobe is seen.
module arbitro_rr (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] Req,
  input  logic       Advance,
  output logic [1:0] Winner
);

  logic prioR;

  // priority pointer, toggled once per completed grant
  always_ff @(posedge Clock) begin
    if (Reset) begin
      prioR <= 1'b0;
    end else if (Advance) begin
      prioR <= ~prioR;
    end else begin
      prioR <= prioR;
    end
  end

  // one-hot winner among the active requests
  always_comb begin
    Winner = 2'b00;
    if (prioR) begin
      if (Req[1])      Winner = 2'b10;
      else if (Req[0]) Winner = 2'b01;
      else             Winner = 2'b00;
    end else begin
      if (Req[0])      Winner = 2'b01;
      else if (Req[1]) Winner = 2'b10;
      else             Winner = 2'b00;
    end
  end

endmodule

// File: rtl/arbitro_diretorio.sv
// MSI directory controller for two caches: arbitrates requests, issues
// invalidate / write-back commands to the remote cache and grants the new state.
module arbitro_diretorio
  import diretorio_pkg::*;
#(
  parameter int N_BLOCKS = N_BLOCKS_DEF,
  localparam int AW = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [1:0]    Req,
  input  logic          WriteRead0,
  input  logic          WriteRead1,
  input  logic [AW-1:0] Addr0,
  input  logic [AW-1:0] Addr1,
  output logic [1:0]    Grant,
  output logic [1:0]    GrantState,
  output logic [1:0]    Invalidate,
  input  logic [1:0]    InvAck,
  output logic [1:0]    WriteBack,
  input  logic [1:0]    WbAck,
  output logic          Busy
);

  fsmState_e     stateR, stateNextS;
  logic          reqIdxR, opR;
  logic [AW-1:0] addrR;
  logic [1:0]    newStateR, newVecR;
  logic [1:0]    grantR, grantStateR, invR, wbR;
  logic          busyR;
  logic [1:0]    dirStR  [N_BLOCKS];
  logic [1:0]    dirVecR [N_BLOCKS];

  logic [1:0]    winnerS, meS, otherS, curStS, curVecS;
  logic [1:0]    lkStS, lkVecS, lkInvS, lkWbS;
  logic [1:0]    invLeftS, wbLeftS, finStS, finVecS;
  logic          grantNowS;

  arbitro_rr uArb (
    .Clock   (Clock),
    .Reset   (Reset),
    .Req     (Req),
    .Advance (stateR == GRANT),
    .Winner  (winnerS)
  );

  // FSM state register
  always_ff @(posedge Clock) begin
    if (Reset) stateR <= IDLE;
    else       stateR <= stateNextS;
  end

  // directory lookup decision and next-state logic
  always_comb begin
    meS      = oneHot(reqIdxR);
    otherS   = oneHot(~reqIdxR);
    curStS   = dirStR[addrR];
    curVecS  = dirVecR[addrR];
    lkStS    = curStS;
    lkVecS   = curVecS;
    lkInvS   = 2'b00;
    lkWbS    = 2'b00;
    invLeftS = invR & ~InvAck;
    wbLeftS  = wbR & ~WbAck;
    finStS   = newStateR;
    finVecS  = newVecR;
    stateNextS = stateR;

    if (curStS == ST_M && (curVecS & meS) != 2'b00) begin
      lkStS  = ST_M;
      lkVecS = curVecS;
    end else if (!opR) begin
      case (curStS)
        ST_S:    begin lkStS = ST_S; lkVecS = curVecS | meS; end
        ST_M:    begin lkStS = ST_S; lkVecS = 2'b11; lkWbS = otherS; end
        default: begin lkStS = ST_S; lkVecS = meS; end
      endcase
    end else begin
      lkStS  = ST_M;
      lkVecS = meS;
      case (curStS)
        ST_S:    lkInvS = ((curVecS & otherS) != 2'b00) ? otherS : 2'b00;
        ST_M:    begin lkInvS = otherS; lkWbS = otherS; end
        default: lkInvS = 2'b00;
      endcase
    end

    if (stateR == LOOKUP) begin
      finStS  = lkStS;
      finVecS = lkVecS;
    end else begin
      finStS  = newStateR;
      finVecS = newVecR;
    end

    case (stateR)
      IDLE:     stateNextS = (winnerS != 2'b00) ? LOOKUP : IDLE;
      LOOKUP:   stateNextS = ((lkInvS | lkWbS) != 2'b00) ? WAIT_ACK : GRANT;
      WAIT_ACK: stateNextS = ((invLeftS | wbLeftS) == 2'b00) ? GRANT : WAIT_ACK;
      GRANT:    stateNextS = IDLE;
      default:  stateNextS = IDLE;
    endcase

    grantNowS = (stateNextS == GRANT) && (stateR != GRANT);
  end

  // transaction latch, command outputs, grant pulse and directory update
  always_ff @(posedge Clock) begin
    if (Reset) begin
      reqIdxR     <= 1'b0;
      opR         <= 1'b0;
      addrR       <= {AW{1'b0}};
      newStateR   <= 2'b00;
      newVecR     <= 2'b00;
      grantR      <= 2'b00;
      grantStateR <= 2'b00;
      invR        <= 2'b00;
      wbR         <= 2'b00;
      busyR       <= 1'b0;
      for (int k = 0; k < N_BLOCKS; k++) begin
        dirStR[k]  <= ST_I;
        dirVecR[k] <= 2'b00;
      end
    end else begin
      busyR       <= (stateNextS != IDLE);
      grantR      <= 2'b00;
      grantStateR <= 2'b00;
      case (stateR)
        IDLE: begin
          if (winnerS != 2'b00) begin
            reqIdxR <= winnerS[1];
            opR     <= winnerS[1] ? WriteRead1 : WriteRead0;
            addrR   <= winnerS[1] ? Addr1 : Addr0;
          end
        end
        LOOKUP: begin
          newStateR <= lkStS;
          newVecR   <= lkVecS;
          invR      <= lkInvS;
          wbR       <= lkWbS;
        end
        // an acked command drops next cycle; the cleared bit is the latched ack
        WAIT_ACK: begin
          invR <= invLeftS;
          wbR  <= wbLeftS;
        end
        default: begin
          invR <= invR;
          wbR  <= wbR;
        end
      endcase
      if (grantNowS) begin
        grantR         <= meS;
        grantStateR    <= finStS;
        dirStR[addrR]  <= finStS;
        dirVecR[addrR] <= finVecS;
      end
    end
  end

  assign Grant      = grantR;
  assign GrantState = grantStateR;
  assign Invalidate = invR;
  assign WriteBack  = wbR;
  assign Busy       = busyR;

endmodule

// File: tb/tb_arbitro_diretorio.sv
// Self-checking bench for arbitro_diretorio: scenario tasks drive requests and
// acks; a scoreboard pairs every Grant pulse with the expectation queued at drive time.
module tb_arbitro_diretorio;
  import diretorio_pkg::*;

  logic       Clock;
  logic       Reset;
  logic [1:0] Req;
  logic       WriteRead0, WriteRead1;
  logic [1:0] Addr0, Addr1;
  logic [1:0] Grant, GrantState, Invalidate, WriteBack;
  logic [1:0] InvAck, WbAck;
  logic       Busy;

  typedef struct packed {
    logic [1:0] g;
    logic [1:0] s;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;
  int   nCompared;
  int   nMismatched;

  arbitro_diretorio #(.N_BLOCKS(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Req        (Req),
    .WriteRead0 (WriteRead0),
    .WriteRead1 (WriteRead1),
    .Addr0      (Addr0),
    .Addr1      (Addr1),
    .Grant      (Grant),
    .GrantState (GrantState),
    .Invalidate (Invalidate),
    .InvAck     (InvAck),
    .WriteBack  (WriteBack),
    .WbAck      (WbAck),
    .Busy       (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // every Grant pulse must match the oldest queued expectation
  always @(negedge Clock) begin
    if (Grant !== 2'b00) begin
      nCompared++;
      if (sbQ.size() == 0) begin
        nMismatched++;
        $display("FAIL sb_unexpected_grant: Grant=%b GrantState=%0d, required no grant", Grant, GrantState);
      end else begin
        monE = sbQ.pop_front();
        if (Grant !== monE.g || GrantState !== monE.s) begin
          nMismatched++;
          $display("FAIL sb_grant: Grant=%b GrantState=%0d, required Grant=%b GrantState=%0d",
                   Grant, GrantState, monE.g, monE.s);
        end
      end
    end
  end

  task automatic doReset();
    Reset = 1'b1;
    Req   = 2'b00;
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  task automatic settle();
    @(posedge Clock); #1;
  endtask

  task automatic driveReq(input int c, input logic wr, input logic [1:0] a,
                          input logic push, input logic [1:0] st);
    exp_t t;
    if (c == 0) begin
      WriteRead0 = wr; Addr0 = a; Req[0] = 1'b1; t.g = 2'b01;
    end else begin
      WriteRead1 = wr; Addr1 = a; Req[1] = 1'b1; t.g = 2'b10;
    end
    t.s = st;
    if (push) sbQ.push_back(t);
  endtask

  task automatic waitGrant(output int cycles, output logic [1:0] cmdSeen);
    cycles  = 0;
    cmdSeen = 2'b00;
    while (cycles < 20) begin
      @(posedge Clock); #1;
      cycles++;
      cmdSeen = cmdSeen | Invalidate | WriteBack;
      if (Grant !== 2'b00) break;
    end
  endtask

  task automatic waitCmd(output int cycles);
    cycles = 0;
    while (cycles < 20) begin
      @(posedge Clock); #1;
      cycles++;
      if ((Invalidate | WriteBack) !== 2'b00) break;
    end
  endtask

  task automatic test_reset();
    doReset();
    nCompared++;
    if (Grant !== 2'b00 || GrantState !== 2'b00 || Invalidate !== 2'b00 ||
        WriteBack !== 2'b00 || Busy !== 1'b0) begin
      nMismatched++;
      $display("FAIL reset_outputs: G=%b GS=%b Inv=%b Wb=%b Busy=%b, required all 0",
               Grant, GrantState, Invalidate, WriteBack, Busy);
    end
  endtask

  task automatic test_read_miss();
    int cyc;
    logic [1:0] cmd;
    driveReq(0, 1'b0, 2'd1, 1'b1, ST_S);
    waitGrant(cyc, cmd);
    Req = 2'b00;
    nCompared++;
    if (cyc !== 2 || cmd !== 2'b00 || Busy !== 1'b1) begin
      nMismatched++;
      $display("FAIL read_miss_latency: cycles=%0d cmd=%b busy=%b, required 2/00/1", cyc, cmd, Busy);
    end
    settle();
    nCompared++;
    if (Busy !== 1'b0) begin
      nMismatched++;
      $display("FAIL idle_busy: Busy=%b, required 0", Busy);
    end
    // block 1 now shared by cache 0 only: a write by cache 1 invalidates cache 0
    driveReq(1, 1'b1, 2'd1, 1'b1, ST_M);
    waitCmd(cyc);
    nCompared++;
    if (cyc !== 2 || Invalidate !== 2'b01 || WriteBack !== 2'b00) begin
      nMismatched++;
      $display("FAIL entry1_sharer0: cycles=%0d Inv=%b Wb=%b, required 2/01/00", cyc, Invalidate, WriteBack);
    end
    InvAck = 2'b01;
    settle();
    InvAck = 2'b00;
    Req    = 2'b00;
    nCompared++;
    if (Invalidate !== 2'b00 || Grant !== 2'b10) begin
      nMismatched++;
      $display("FAIL inv_release: Inv=%b Grant=%b, required 00/10", Invalidate, Grant);
    end
    settle();
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [1:0] cmd;
    doReset();
    driveReq(0, 1'b0, 2'd2, 1'b1, ST_S);
    driveReq(1, 1'b0, 2'd2, 1'b1, ST_S);
    waitGrant(cyc, cmd);
    nCompared++;
    if (Grant !== 2'b01 || cyc !== 2) begin
      nMismatched++;
      $display("FAIL rr_first: Grant=%b cycles=%0d, required 01/2", Grant, cyc);
    end
    Req[0] = 1'b0;
    waitGrant(cyc, cmd);
    nCompared++;
    if (Grant !== 2'b10 || cyc < 2 || cyc > 5 || cmd !== 2'b00) begin
      nMismatched++;
      $display("FAIL rr_second: Grant=%b cycles=%0d cmd=%b, required 10/2..5/00", Grant, cyc, cmd);
    end
    Req = 2'b00;
    settle();
  endtask

  task automatic test_write_invalidate();
    int cyc;
    driveReq(1, 1'b1, 2'd2, 1'b1, ST_M);
    waitCmd(cyc);
    nCompared++;
    if (Invalidate !== 2'b01 || WriteBack !== 2'b00) begin
      nMismatched++;
      $display("FAIL write_shared_inv: Inv=%b Wb=%b, required 01/00", Invalidate, WriteBack);
    end
    WbAck  = 2'b11;
    InvAck = 2'b10;
    settle();
    WbAck  = 2'b00;
    InvAck = 2'b00;
    settle();
    nCompared++;
    if (Invalidate !== 2'b01 || Grant !== 2'b00 || Busy !== 1'b1) begin
      nMismatched++;
      $display("FAIL spurious_ack_ignored: Inv=%b Grant=%b Busy=%b, required 01/00/1", Invalidate, Grant, Busy);
    end
    InvAck = 2'b01;
    settle();
    InvAck = 2'b00;
    Req    = 2'b00;
    nCompared++;
    if (Grant !== 2'b10 || Invalidate !== 2'b00) begin
      nMismatched++;
      $display("FAIL grant_after_inv: Grant=%b Inv=%b, required 10/00", Grant, Invalidate);
    end
    settle();
  endtask

  task automatic test_writeback();
    int cyc;
    int held;
    driveReq(0, 1'b0, 2'd2, 1'b1, ST_S);
    waitCmd(cyc);
    held = 0;
    for (int k = 0; k < 5; k++) begin
      if (WriteBack === 2'b10 && Invalidate === 2'b00 && Grant === 2'b00) held++;
      if (k < 4) settle();
    end
    nCompared++;
    if (held !== 5) begin
      nMismatched++;
      $display("FAIL wb_held: cycles held=%0d, required 5", held);
    end
    WbAck = 2'b10;
    settle();
    WbAck = 2'b00;
    Req   = 2'b00;
    nCompared++;
    if (Grant !== 2'b01 || WriteBack !== 2'b00) begin
      nMismatched++;
      $display("FAIL grant_after_wb: Grant=%b Wb=%b, required 01/00", Grant, WriteBack);
    end
    settle();
    // block 2 must now be shared with cache 1: a write by cache 0 invalidates it
    driveReq(0, 1'b1, 2'd2, 1'b1, ST_M);
    waitCmd(cyc);
    nCompared++;
    if (Invalidate !== 2'b10 || WriteBack !== 2'b00) begin
      nMismatched++;
      $display("FAIL entry2_shared: Inv=%b Wb=%b, required 10/00", Invalidate, WriteBack);
    end
    InvAck = 2'b10;
    settle();
    InvAck = 2'b00;
    Req    = 2'b00;
    settle();
  endtask

  task automatic test_dual_ack();
    int cyc;
    logic [1:0] cmd;
    driveReq(0, 1'b1, 2'd3, 1'b1, ST_M);
    waitGrant(cyc, cmd);
    Req = 2'b00;
    nCompared++;
    if (cyc !== 2 || cmd !== 2'b00) begin
      nMismatched++;
      $display("FAIL write_invalid: cycles=%0d cmd=%b, required 2/00", cyc, cmd);
    end
    settle();
    driveReq(1, 1'b1, 2'd3, 1'b1, ST_M);
    waitCmd(cyc);
    nCompared++;
    if (Invalidate !== 2'b01 || WriteBack !== 2'b01) begin
      nMismatched++;
      $display("FAIL write_modified_cmds: Inv=%b Wb=%b, required 01/01", Invalidate, WriteBack);
    end
    InvAck = 2'b01;
    settle();
    InvAck = 2'b00;
    nCompared++;
    if (Invalidate !== 2'b00 || WriteBack !== 2'b01 || Grant !== 2'b00) begin
      nMismatched++;
      $display("FAIL inv_ack_first: Inv=%b Wb=%b Grant=%b, required 00/01/00", Invalidate, WriteBack, Grant);
    end
    settle();
    WbAck = 2'b01;
    settle();
    WbAck = 2'b00;
    Req   = 2'b00;
    nCompared++;
    if (Grant !== 2'b10 || WriteBack !== 2'b00) begin
      nMismatched++;
      $display("FAIL grant_after_both: Grant=%b Wb=%b, required 10/00", Grant, WriteBack);
    end
    settle();
    driveReq(1, 1'b0, 2'd3, 1'b1, ST_M);
    waitGrant(cyc, cmd);
    Req = 2'b00;
    nCompared++;
    if (cyc !== 2 || cmd !== 2'b00) begin
      nMismatched++;
      $display("FAIL owner_read: cycles=%0d cmd=%b, required 2/00", cyc, cmd);
    end
    settle();
  endtask

  task automatic test_reset_abort();
    int cyc;
    logic [1:0] cmd;
    logic [1:0] gSeen;
    driveReq(1, 1'b0, 2'd2, 1'b0, ST_S);
    waitCmd(cyc);
    nCompared++;
    if (WriteBack !== 2'b01 || Invalidate !== 2'b00) begin
      nMismatched++;
      $display("FAIL abort_setup: Wb=%b Inv=%b, required 01/00", WriteBack, Invalidate);
    end
    Reset = 1'b1;
    settle();
    Reset = 1'b0;
    Req   = 2'b00;
    nCompared++;
    if (Grant !== 2'b00 || GrantState !== 2'b00 || Invalidate !== 2'b00 ||
        WriteBack !== 2'b00 || Busy !== 1'b0) begin
      nMismatched++;
      $display("FAIL reset_abort_outputs: G=%b GS=%b Inv=%b Wb=%b Busy=%b, required all 0",
               Grant, GrantState, Invalidate, WriteBack, Busy);
    end
    gSeen = 2'b00;
    for (int k = 0; k < 4; k++) begin
      settle();
      gSeen = gSeen | Grant;
    end
    nCompared++;
    if (gSeen !== 2'b00) begin
      nMismatched++;
      $display("FAIL reset_abort_nogrant: Grant seen=%b, required 00", gSeen);
    end
    for (int b = 0; b < 4; b++) begin
      driveReq(1, 1'b1, b[1:0], 1'b1, ST_M);
      waitGrant(cyc, cmd);
      Req = 2'b00;
      nCompared++;
      if (cyc !== 2 || cmd !== 2'b00 || Grant !== 2'b10) begin
        nMismatched++;
        $display("FAIL entry_reset_%0d: cycles=%0d cmd=%b Grant=%b, required 2/00/10", b, cyc, cmd, Grant);
      end
      settle();
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    Reset      = 1'b1;
    Req        = 2'b00;
    WriteRead0 = 1'b0;
    WriteRead1 = 1'b0;
    Addr0      = 2'd0;
    Addr1      = 2'd0;
    InvAck     = 2'b00;
    WbAck      = 2'b00;
    @(posedge Clock); #1;
    test_reset();
    test_read_miss();
    test_back_to_back();
    test_write_invalidate();
    test_writeback();
    test_dual_ack();
    test_reset_abort();
    settle();
    nCompared++;
    if (sbQ.size() != 0) begin
      nMismatched++;
      $display("FAIL sb_drain: %0d expected grants never seen, required 0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/arbitro_diretorio.md
ARBITRO_DIRETORIO -- requirements
Module: arbitro_diretorio

Interface
REQ-001 The module SHALL have a parameter N_BLOCKS, default 4, giving the number of tracked blocks; the address width is log2(N_BLOCKS).
REQ-002 Clock  input  1  single clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Req  input  2  per-cache request; bit i belongs to cache i.
REQ-005 WriteRead0 / WriteRead1  input  1 each  operation of cache 0/1: 1 = write miss/upgrade, 0 = read miss.
REQ-006 Addr0 / Addr1  input  log2(N_BLOCKS) each  block index of cache 0/1.
REQ-007 Grant  output  2  one-hot, one-cycle completion pulse to the served cache.
REQ-008 GrantState  output  2  new cache state for the granted cache, valid only while Grant is non-zero.
REQ-009 Invalidate  output  2  invalidate command to cache j, held until the matching ack.
REQ-010 InvAck  input  2  invalidate acknowledge from cache j.
REQ-011 WriteBack  output  2  write-back/flush command to owner cache j, held until the matching ack.
REQ-012 WbAck  input  2  write-back acknowledge from cache j.
REQ-013 Busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 Each directory entry SHALL hold state I=0, S=1 or M=2 (2 bits) plus a 2-bit sharer/owner vector.
REQ-015 Arbitration SHALL be two-way round-robin: after reset cache 0 has priority, and after each Grant priority passes to the other cache.
REQ-016 FSM states SHALL be IDLE, LOOKUP, WAIT_ACK and GRANT.
  - IDLE->LOOKUP when any Req bit is high: latch the winner, its op and its address.
  - LOOKUP->WAIT_ACK if a command is issued, otherwise LOOKUP->GRANT.
  - WAIT_ACK->GRANT once all required acks are seen.
  - GRANT->IDLE unconditionally.
REQ-017 With no remote action, Grant SHALL pulse exactly 2 cycles after the cycle in which IDLE sampled Req.
REQ-018 LOOKUP actions, for requester i and other cache j:
  - Read, entry I: entry -> S, sharers = {i}; grant S.
  - Read, entry S: add i to sharers; grant S.
  - Read, entry M with owner j: assert WriteBack[j] and wait for WbAck[j]; then entry -> S, sharers = {i,j}; grant S.
  - Write, entry I, or entry S with sharers ⊆ {i}: entry -> M, owner = i; grant M.
  - Write, entry S with j a sharer: assert Invalidate[j] and wait for InvAck[j]; then entry -> M, owner = i; grant M.
  - Write, entry M with owner j: assert both WriteBack[j] and Invalidate[j]; wait until both acks are seen, in either order or in the same cycle; then entry -> M, owner = i; grant M.
  - Any op, entry M with owner i: no change; grant M.
REQ-019 Each command output SHALL deassert in the cycle after its ack is sampled; acks SHALL be latched, so an ack held for one cycle suffices.
REQ-020 Acks arriving when not awaited SHALL be ignored.
REQ-021 The directory entry SHALL be written in the same cycle Grant is asserted.
REQ-022 A requester SHALL hold Req, WriteRead and Addr until its Grant; if Req drops mid-transaction, the transaction still completes and Grant still pulses.
REQ-023 On simultaneous requests, only the priority cache SHALL be served; the loser is served next, two or more cycles later, if its Req is still high.
REQ-024 Grant, Invalidate and WriteBack SHALL never target a cache outside the defined rules, and Invalidate/WriteBack SHALL never target the requester itself.

Reset
REQ-025 While Reset is high at a Clock edge:
  - FSM -> IDLE, priority -> cache 0, all entries -> I with an empty vector.
  - Grant, GrantState, Invalidate, WriteBack and Busy SHALL all be 0 from the next cycle.
REQ-026 Reset SHALL abort any in-flight transaction without issuing a Grant.

Structure
REQ-027 Package diretorio_pkg SHALL hold the I/S/M encodings, the FSM state enum and the default N_BLOCKS.
REQ-028 Round-robin selection SHALL be a sub-module arbitro_rr (inputs: Req and an advance strobe; outputs: one-hot winner).

Verification
REQ-029 After reset, cache 0 reads block 1 -> Grant=01 with GrantState=S at t+2, and entry 1 = S {0}.
REQ-030 Both caches read block 2 in the same cycle -> cache 0 is granted S first, then cache 1 is granted S; entry 2 = S {0,1}.
REQ-031 Block 2 in S {0,1}, cache 1 writes -> Invalidate=01 until InvAck[0], then Grant=10 with GrantState=M; entry 2 = M owner 1.
REQ-032 Block 2 in M owner 1, cache 0 reads, WbAck delayed 5 cycles -> WriteBack=10 held 5 cycles, then Grant=01 with GrantState=S; entry 2 = S {0,1}.
REQ-033 Block 3 in M owner 0, cache 1 writes, InvAck and WbAck 2 cycles apart -> Grant only after the second ack; entry 3 = M owner 1.
REQ-034 Reset pulsed during WAIT_ACK -> all outputs 0 next cycle, no Grant, and every entry reads I afterwards.
